// File: rtl/simon_core.sv
// Iterative Simon block cipher: one-time key expansion into a round-key store,
// then one round per cycle in either direction behind valid/ready handshakes.
module simon_core #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_load,
  input  logic [N*M-1:0] key,
  output logic           key_ready,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_mode,
  input  logic [2*N-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_data
);

  function automatic int unsigned f_rounds(input int unsigned n, input int unsigned m);
    case (n)
      16:      return (m == 4) ? 32 : 0;
      24:      return (m == 3 || m == 4) ? 36 : 0;
      32:      return (m == 3) ? 42 : (m == 4) ? 44 : 0;
      48:      return (m == 2) ? 52 : (m == 3) ? 54 : 0;
      64:      return (m == 2) ? 68 : (m == 3) ? 69 : (m == 4) ? 72 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned f_zidx(input int unsigned n, input int unsigned m);
    case (n)
      16:      return 0;
      24:      return (m == 3) ? 0 : 1;
      32:      return (m == 3) ? 2 : 3;
      48:      return (m == 2) ? 2 : 3;
      default: return (m == 2) ? 2 : (m == 3) ? 3 : 4;
    endcase
  endfunction

  // Bit 61 holds z[0], the first element of each published sequence.
  function automatic logic [61:0] f_zseq(input int unsigned idx);
    case (idx)
      0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: return 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  localparam int unsigned T     = f_rounds(N, M);
  localparam int unsigned Z_IDX = f_zidx(N, M);
  localparam int unsigned CW    = (T > 1) ? $clog2(T) : 1;
  localparam logic [61:0] Z_SEQ = f_zseq(Z_IDX);

  if (T == 0) begin : g_illegal_params
    $error("simon_core: unsupported (N,M) combination");
  end

  function automatic logic [N-1:0] f_rol(input logic [N-1:0] x, input int unsigned s);
    return (x << s) | (x >> (N - s));
  endfunction

  function automatic logic [N-1:0] f_ror(input logic [N-1:0] x, input int unsigned s);
    return (x >> s) | (x << (N - s));
  endfunction

  function automatic logic [N-1:0] f_f(input logic [N-1:0] x);
    return (f_rol(x, 1) & f_rol(x, 8)) ^ f_rol(x, 2);
  endfunction

  typedef enum logic [2:0] {S_NOKEY, S_KEXP, S_IDLE, S_RUN, S_OUT} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_x;
  logic [N-1:0]   r_y;
  logic           r_mode;
  logic [N*M-1:0] r_key;
  logic           r_kpend;
  logic           r_key_ready;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [2*N-1:0] r_out_data;
  logic [N-1:0]   r_rk [T];

  logic [N-1:0]   w_rk;
  logic [N-1:0]   w_tmp;
  logic [N-1:0]   w_knew;
  logic [N-1:0]   w_nx;
  logic [N-1:0]   w_ny;
  logic           w_zbit;
  logic           w_last;
  int unsigned    w_zpos;

  // Next round key (while expanding) and next round state (while running).
  always_comb begin
    w_rk   = r_rk[r_cnt];
    w_zpos = 32'(r_cnt) - M;
    if (w_zpos >= 32'd62) w_zpos = w_zpos - 32'd62;
    w_zbit = (w_zpos < 32'd62) ? Z_SEQ[6'(32'd61 - w_zpos)] : 1'b0;
    w_tmp  = f_ror(r_rk[CW'(r_cnt - CW'(1))], 3);
    if (M == 4) w_tmp = w_tmp ^ r_rk[CW'(r_cnt - CW'(3))];
    w_tmp  = w_tmp ^ f_ror(w_tmp, 1);
    w_knew = ~r_rk[CW'(r_cnt - CW'(M))] ^ w_tmp ^ N'(w_zbit) ^ N'(3);
    if (r_mode) begin
      w_nx = r_y;
      w_ny = r_x ^ f_f(r_y) ^ w_rk;
    end else begin
      w_nx = r_y ^ f_f(r_x) ^ w_rk;
      w_ny = r_x;
    end
    w_last = r_mode ? (r_cnt == '0) : (r_cnt == CW'(T - 1));
  end

  // Round-key store; validity is tracked by r_key_ready, so no reset is needed.
  always_ff @(posedge clk) begin
    if (r_state == S_KEXP) begin
      if (r_cnt == '0) begin
        for (int i = 0; i < int'(M); i++) r_rk[CW'(i)] <= r_key[i*N +: N];
      end else begin
        r_rk[r_cnt] <= w_knew;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_NOKEY;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_mode      <= 1'b0;
      r_key       <= '0;
      r_kpend     <= 1'b0;
      r_key_ready <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (key_load) r_key <= key;
      case (r_state)
        S_NOKEY: begin
          if (key_load) begin
            r_state <= S_KEXP;
            r_cnt   <= '0;
          end
        end
        S_KEXP: begin
          if (key_load) begin
            r_cnt <= '0;
          end else if (r_cnt == '0) begin
            r_cnt <= CW'(M);
          end else if (r_cnt == CW'(T - 1)) begin
            r_state     <= S_IDLE;
            r_key_ready <= 1'b1;
            r_in_ready  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (key_load) begin
            r_state     <= S_KEXP;
            r_cnt       <= '0;
            r_key_ready <= 1'b0;
            r_in_ready  <= 1'b0;
          end else if (in_valid && r_in_ready) begin
            r_state    <= S_RUN;
            r_x        <= in_data[2*N-1:N];
            r_y        <= in_data[N-1:0];
            r_mode     <= in_mode;
            r_cnt      <= in_mode ? CW'(T - 1) : '0;
            r_in_ready <= 1'b0;
          end
        end
        S_RUN: begin
          if (key_load) r_kpend <= 1'b1;
          r_x <= w_nx;
          r_y <= w_ny;
          if (w_last) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= {w_nx, w_ny};
          end else begin
            r_cnt <= r_mode ? r_cnt - CW'(1) : r_cnt + CW'(1);
          end
        end
        S_OUT: begin
          // A new key (fresh or deferred from S_RUN) discards or follows the result.
          if (key_load || (out_ready && r_kpend)) begin
            r_state     <= S_KEXP;
            r_cnt       <= '0;
            r_kpend     <= 1'b0;
            r_key_ready <= 1'b0;
            r_out_valid <= 1'b0;
          end else if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_NOKEY;
      endcase
    end
  end

  assign key_ready = r_key_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_simon_core.sv
// Directed bench for simon_core: Simon32/64 and Simon64/128 known-answer vectors,
// handshake timing, back-pressure, key reload and asynchronous reset.
module tb_simon_core;

  localparam logic [63:0]  KEY_A = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  PT_A  = 32'h6565_6877;
  localparam logic [31:0]  CT_A  = 32'hc69b_e9bb;
  localparam logic [127:0] KEY_B = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT_B  = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT_B  = 64'h44c8fc20_b9dfa07a;
  // Edges counted inclusively: accept edge .. out_valid edge = T+1,
  // key_load edge .. key_ready edge = 1 + (T-M+1).
  localparam int LAT_A  = 33;
  localparam int KEXP_A = 30;
  localparam int LAT_B  = 45;
  localparam int KEXP_B = 42;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         kl_a, kr_a, iv_a, ir_a, im_a, ov_a, or_a;
  logic [63:0]  key_a;
  logic [31:0]  id_a, od_a;
  logic         kl_b, kr_b, iv_b, ir_b, im_b, ov_b, or_b;
  logic [127:0] key_b;
  logic [63:0]  id_b, od_b;

  int checks = 0;
  int errors = 0;

  simon_core #(.N(16), .M(4)) u_dut_a (
    .clk(clk), .rst(rst), .key_load(kl_a), .key(key_a), .key_ready(kr_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_mode(im_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a)
  );

  simon_core #(.N(32), .M(4)) u_dut_b (
    .clk(clk), .rst(rst), .key_load(kl_b), .key(key_b), .key_ready(kr_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_mode(im_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: they only drive and measure; callers compare.
  task automatic key_a_pulse(input logic [63:0] k, output int edges);
    key_a = k; kl_a = 1'b1;
    @(negedge clk);
    kl_a = 1'b0; key_a = ~k;
    edges = 1;
    while (!kr_a && edges < 200) begin @(negedge clk); edges++; end
    if (!kr_a) edges = -1;
  endtask

  task automatic key_b_pulse(input logic [127:0] k, output int edges);
    key_b = k; kl_b = 1'b1;
    @(negedge clk);
    kl_b = 1'b0; key_b = ~k;
    edges = 1;
    while (!kr_b && edges < 200) begin @(negedge clk); edges++; end
    if (!kr_b) edges = -1;
  endtask

  task automatic block_a(input logic mode, input logic [31:0] d,
                         output logic [31:0] q, output int lat, output int kr_drops);
    iv_a = 1'b1; im_a = mode; id_a = d; lat = 0; kr_drops = 0;
    do begin
      @(negedge clk); lat++;
      iv_a = 1'b0; id_a = 32'hdead_beef;
      if (!kr_a) kr_drops++;
    end while (!ov_a && lat < 200);
    if (!ov_a) lat = -1;
    q = od_a;
    @(negedge clk);
  endtask

  task automatic block_b(input logic mode, input logic [63:0] d,
                         output logic [63:0] q, output int lat);
    iv_b = 1'b1; im_b = mode; id_b = d; lat = 0;
    do begin
      @(negedge clk); lat++;
      iv_b = 1'b0; id_b = 64'hdead_beef_dead_beef;
    end while (!ov_b && lat < 200);
    if (!ov_b) lat = -1;
    q = od_b;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (kr_a !== 1'b0) begin errors++; $display("FAIL reset_key_ready got=%b exp=0", kr_a); end
    checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", ir_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov_a); end
    checks++; if (od_a !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", od_a); end
    checks++; if (kr_b !== 1'b0) begin errors++; $display("FAIL reset_key_ready_b got=%b exp=0", kr_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_key();
    int bad = 0;
    iv_a = 1'b1; im_a = 1'b0; id_a = PT_A;
    repeat (100) begin
      @(negedge clk);
      if (ir_a !== 1'b0 || ov_a !== 1'b0 || kr_a !== 1'b0) bad++;
    end
    iv_a = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL no_key_accept bad_cycles=%0d exp=0", bad); end
    checks++; if (od_a !== 32'h0) begin errors++; $display("FAIL no_key_out_data got=%h exp=0", od_a); end
  endtask

  task automatic test_key_expansion();
    int e;
    key_a_pulse(KEY_A, e);
    checks++; if (e !== KEXP_A) begin errors++; $display("FAIL kexp_latency_a got=%0d exp=%0d", e, KEXP_A); end
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL kexp_in_ready got=%b exp=1", ir_a); end
  endtask

  task automatic test_encrypt_decrypt();
    logic [31:0] q;
    int lat, drops;
    block_a(1'b0, PT_A, q, lat, drops);
    checks++; if (q !== CT_A) begin errors++; $display("FAIL enc_a got=%h exp=%h", q, CT_A); end
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL enc_a_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (ov_a !== 1'b0 || ir_a !== 1'b1) begin errors++; $display("FAIL enc_a_return_idle got_ov=%b got_ir=%b exp=0/1", ov_a, ir_a); end
    block_a(1'b1, CT_A, q, lat, drops);
    checks++; if (q !== PT_A) begin errors++; $display("FAIL dec_a got=%h exp=%h", q, PT_A); end
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL dec_a_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL dec_a_key_ready drops=%0d exp=0", drops); end
  endtask

  task automatic test_simon64();
    logic [63:0] q;
    int e, lat;
    key_b_pulse(KEY_B, e);
    checks++; if (e !== KEXP_B) begin errors++; $display("FAIL kexp_latency_b got=%0d exp=%0d", e, KEXP_B); end
    block_b(1'b0, PT_B, q, lat);
    checks++; if (q !== CT_B) begin errors++; $display("FAIL enc_b got=%h exp=%h", q, CT_B); end
    checks++; if (lat !== LAT_B) begin errors++; $display("FAIL enc_b_latency got=%0d exp=%0d", lat, LAT_B); end
    block_b(1'b1, CT_B, q, lat);
    checks++; if (q !== PT_B) begin errors++; $display("FAIL dec_b got=%h exp=%h", q, PT_B); end
  endtask

  task automatic test_back_pressure();
    int lat, busy_bad, hold_bad;
    or_a = 1'b0; iv_a = 1'b1; im_a = 1'b0; id_a = PT_A;
    @(negedge clk);
    id_a = CT_A; im_a = 1'b1;
    lat = 1; busy_bad = 0;
    while (!ov_a && lat < 200) begin
      if (ir_a) busy_bad++;
      @(negedge clk); lat++;
    end
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL bp_in_ready_run bad=%0d exp=0", busy_bad); end
    hold_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (od_a !== CT_A || ir_a !== 1'b0 || ov_a !== 1'b1) hold_bad++;
    end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold bad=%0d exp=0 data=%h", hold_bad, od_a); end
    or_a = 1'b1;
    @(negedge clk);
    checks++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin errors++; $display("FAIL bp_release got_ir=%b got_ov=%b exp=1/0", ir_a, ov_a); end
    @(negedge clk);
    checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL bp_queued_accept got_ir=%b exp=0", ir_a); end
    iv_a = 1'b0;
    lat = 1;
    while (!ov_a && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (od_a !== PT_A) begin errors++; $display("FAIL bp_second_data got=%h exp=%h", od_a, PT_A); end
    @(negedge clk);
  endtask

  task automatic test_key_load_run();
    logic [31:0] q;
    int lat, kr_bad, e, drops;
    logic kr_first;
    iv_a = 1'b1; im_a = 1'b0; id_a = PT_A;
    @(negedge clk);
    iv_a = 1'b0; lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    key_a = 64'h0; kl_a = 1'b1;
    @(negedge clk); lat++;
    kl_a = 1'b0; key_a = 64'hffff_ffff_ffff_ffff;
    kr_bad = 0;
    while (!ov_a && lat < 200) begin
      if (!kr_a) kr_bad++;
      @(negedge clk); lat++;
    end
    checks++; if (lat !== LAT_A) begin errors++; $display("FAIL klrun_latency got=%0d exp=%0d", lat, LAT_A); end
    checks++; if (od_a !== CT_A) begin errors++; $display("FAIL klrun_old_key got=%h exp=%h", od_a, CT_A); end
    checks++; if (kr_bad !== 0) begin errors++; $display("FAIL klrun_key_ready bad=%0d exp=0", kr_bad); end
    e = 0; kr_first = 1'b1;
    do begin
      @(negedge clk); e++;
      if (e == 1) kr_first = kr_a;
    end while (!kr_a && e < 200);
    checks++; if (kr_first !== 1'b0) begin errors++; $display("FAIL klrun_drop got=%b exp=0", kr_first); end
    checks++; if (e !== KEXP_A) begin errors++; $display("FAIL klrun_kexp got=%0d exp=%0d", e, KEXP_A); end
    block_a(1'b0, PT_A, q, lat, drops);
    checks++; if (q === CT_A) begin errors++; $display("FAIL klrun_new_key got=%h exp=not %h", q, CT_A); end
    key_a = 64'h0123_4567_89ab_cdef; kl_a = 1'b1;
    @(negedge clk);
    kl_a = 1'b0;
    checks++; if (kr_a !== 1'b0) begin errors++; $display("FAIL idle_reload_drop got=%b exp=0", kr_a); end
    repeat (5) @(negedge clk);
    key_a_pulse(KEY_A, e);
    checks++; if (e !== KEXP_A) begin errors++; $display("FAIL kexp_restart got=%0d exp=%0d", e, KEXP_A); end
    block_a(1'b0, PT_A, q, lat, drops);
    checks++; if (q !== CT_A) begin errors++; $display("FAIL restart_enc got=%h exp=%h", q, CT_A); end
  endtask

  task automatic test_reset_mid_run();
    iv_a = 1'b1; im_a = 1'b0; id_a = PT_A;
    @(negedge clk);
    iv_a = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (kr_a !== 1'b0) begin errors++; $display("FAIL arst_key_ready got=%b exp=0", kr_a); end
    checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL arst_in_ready got=%b exp=0", ir_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b exp=0", ov_a); end
    checks++; if (od_a !== 32'h0) begin errors++; $display("FAIL arst_out_data got=%h exp=0", od_a); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (kr_a !== 1'b0 || ir_a !== 1'b0) begin errors++; $display("FAIL post_rst_nokey got_kr=%b got_ir=%b exp=0/0", kr_a, ir_a); end
    checks++; if (kr_b !== 1'b0) begin errors++; $display("FAIL post_rst_key_ready_b got=%b exp=0", kr_b); end
  endtask

  initial begin
    rst = 1'b1;
    kl_a = 1'b0; key_a = '0; iv_a = 1'b0; im_a = 1'b0; id_a = '0; or_a = 1'b1;
    kl_b = 1'b0; key_b = '0; iv_b = 1'b0; im_b = 1'b0; id_b = '0; or_b = 1'b1;
    test_reset();
    test_no_key();
    test_key_expansion();
    test_encrypt_decrypt();
    test_simon64();
    test_back_pressure();
    test_key_load_run();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_core.md
Name: simon_core

Overview:
- Iterative Simon block-cipher engine. It is the parametrised successor of the single-shot Simon encryptor, and adds four things:
  - a one-time key-expansion phase into a round-key store,
  - both encrypt and decrypt modes,
  - valid/ready handshakes on input and output,
  - back-to-back blocks under one key without re-expansion.
- Sits behind the bus-mapped crypto peripheral. The CPU loads a key, then streams blocks.

Parameters:
- N, 16, word size in bits; legal values 16, 24, 32, 48, 64.
- M, 4, key words; legal values per the Simon spec (N=16:4; 24:3,4; 32:3,4; 48:2,3; 64:2,3,4).
- T, derived localparam, round count per Simon spec (32/64=32, 48/72=36, 48/96=36, 64/96=42, 64/128=44, 96/96=52, 96/144=54, 128/128=68, 128/192=69, 128/256=72).
- Z_IDX, derived localparam, z-sequence index per Simon spec.
- Any illegal (N,M) pair must cause an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- key_load  in  1  one-cycle pulse that starts key expansion
- key  in  N*M  master key; key[N-1:0]=k0, key[2N-1:N]=k1, ...
- key_ready  out  1  round-key store valid; engine accepts blocks
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept a block
- in_mode  in  1  0=encrypt, 1=decrypt; sampled with the block
- in_data  in  2N  block; [2N-1:N]=x (left word), [N-1:0]=y
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  2N  result, same word layout as in_data

Behaviour:
- Reset (async, any state):
  - state=S_NOKEY; key_ready=0, in_ready=0, out_valid=0, out_data=0.
  - Round-key store contents are undefined, but it is invalidated by key_ready=0.
- Round function, encrypt:
  - (x,y) -> (y ^ f(x) ^ k_i, x), i=0..T-1.
  - f(x) = (ROL1 x & ROL8 x) ^ ROL2 x.
- Round function, decrypt:
  - (x,y) -> (y, x ^ f(y) ^ k_i), i=T-1..0.
- Key schedule, per Simon spec; c = 2^N-4; all arithmetic modulo 2^N:
  - tmp = ROR3 k_{i-1}.
  - If M==4: tmp ^= k_{i-3}.
  - tmp ^= ROR1 tmp.
  - k_i = ~k_{i-M} ^ tmp ^ z[Z_IDX][(i-M) mod 62] ^ 3.
- State machine:
  - S_NOKEY:
    - key_ready=0, in_ready=0.
    - key_load -> S_KEXP.
  - S_KEXP:
    - Cycle 0 writes k0..k_{M-1} from key.
    - Each following cycle writes one k_i, i=M..T-1.
    - Total T-M+1 cycles, then -> S_IDLE with key_ready=1.
  - S_IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch in_data into the x/y registers, latch in_mode, set counter to 0 (enc) or T-1 (dec), -> S_RUN.
  - S_RUN:
    - One round per cycle; the counter increments (enc) or decrements (dec).
    - After exactly T rounds -> S_OUT.
    - out_data is loaded from the x/y registers on the same edge as the last round.
  - S_OUT:
    - out_valid=1; out_data stays stable until out_valid&out_ready.
    - On handshake -> S_IDLE.
- Latency:
  - Accept edge to out_valid high is T+1 cycles.
  - Throughput is one block per T+2 cycles when out_ready is held high.
- key_load in S_IDLE or S_OUT:
  - key_ready drops next cycle and expansion restarts.
  - A pending S_OUT result is discarded: out_valid drops.
- key_load in S_KEXP: expansion restarts from cycle 0 with the new key.
- key_load in S_RUN:
  - Ignored until the block completes.
  - The pulse is remembered in a pending flag; expansion starts on exit from S_OUT.
  - key_ready stays 1 meanwhile.
- key is sampled only in the key_load cycle; later key changes are ignored.
- in_valid while in_ready=0 is not consumed; in_data need not be held stable after acceptance.
- Round keys live in a T x N register array, indexed by a counter with width clog2(T).
- in_ready and out_valid are registered, not combinational from in_valid or out_ready.

Test Plan:
- Simon32/64:
  - key=0x1918_1110_0908_0100, encrypt pt=0x6565_6877 -> out_data=0xc69b_e9bb.
  - out_valid rises exactly 33 cycles after acceptance.
- Same key, decrypt 0xc69b_e9bb -> 0x6565_6877.
  - Key is not reloaded between blocks.
  - key_ready must stay 1 throughout.
- N=32,M=4 (Simon64/128), key=0x1b1a1918_13121110_0b0a0908_03020100:
  - Encrypt 0x656b696c_20646e75 -> 0x44c8fc20_b9dfa07a.
  - Decrypt returns the plaintext.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles after out_valid; out_data must be stable and in_ready must be 0.
  - Release out_ready; a second queued block must be accepted in the next cycle.
- Reset and key_load mid-operation:
  - Assert rst asynchronously mid-S_RUN: all outputs go to 0 immediately and key_ready=0.
  - A key_load pulse during S_RUN: the current block completes with the old key, then expansion runs for T-M+1 cycles before key_ready returns to 1.
- No key: in_valid high after reset with no key_load -> in_ready stays 0 and no block is accepted for 100 cycles.
